regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Shares the register file's single write port between two writeback requesters: req0 (ALU/execute result) and req1 (load data returning from memory). It arbitrates round-robin with a valid/ready handshake and registers the winning write. It then drives the register file's we3/wa3/wd3 inputs directly. Writes targeting X31 (XZR) are accepted and discarded, so the zero register is never written.

## Interface
Parameters:
- DW, 64, data width of a register
- AW, 5, register address width (32 registers)
- CW, 8, width of the XZR-drop counter

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- hold  in  1  pipeline stall; while 1, no request is granted
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  AW  destination register of requester 0
- req0_data  in  DW  write data of requester 0
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid  in  1  requester 1 has a write pending
- req1_addr  in  AW  destination register of requester 1
- req1_data  in  DW  write data of requester 1
- req1_ready  out  1  requester 1 accepted this cycle (combinational)
- we3  out  1  register file write enable (registered)
- wa3  out  AW  register file write address (registered)
- wd3  out  DW  register file write data (registered)
- last_grant  out  1  requester granted most recently (0 or 1)
- xzr_drops  out  CW  count of accepted writes to register 31, saturating

## Operation
- Grant logic is combinational from req*_valid, hold and last_grant:
  - hold=1: no grant.
  - Exactly one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
- reqN_ready = grant to N. An accept is valid & ready; at most one accept per cycle.
- A requester keeps valid, addr and data stable until accepted. The arbiter does not check this.
- On an accept at a rising edge:
  - last_grant <= accepted index.
  - wa3 <= addr, wd3 <= data.
  - we3 <= (addr != 31).
- Accept with addr == 31:
  - ready is still asserted, so the requester is released.
  - we3 <= 0.
  - xzr_drops increments by 1, holding at 2^CW-1 once reached.
- No accept in a cycle: we3 <= 0. wa3/wd3 hold their previous values; they are don't-care while we3=0.
- The output stage never backpressures, because the register file absorbs one write per cycle. No internal queue exists.
- Both requesters targeting the same register in the same cycle: the grant order decides. The later-granted write lands one cycle later and wins the final value.
- Reset (asynchronous, any time):
  - we3=0, wa3=0, wd3=0.
  - last_grant=1, so req0 wins the first tie.
  - xzr_drops=0.
  - A write latched but not yet committed is lost. The ready outputs follow the reset values combinationally.

## Timing
- Accept at edge N drives we3/wa3/wd3 from edge N until edge N+1. The register file commits at edge N+1.
- Latency from valid-with-grant to register contents: 2 rising edges. Readers see the new value after edge N+1.
- Throughput: 1 write per cycle. Under continuous contention each requester gets every other cycle.
- A single active requester is never stalled while hold=0.
- hold rising mid-stream:
  - Cycles with hold=1 accept nothing and force we3=0 on the following edge.
  - An already-latched write still commits.
- reset_n deassertion is synchronised externally. The first grant can occur on the first edge with reset_n=1.

## Test plan
- Single requester: req1 valid, addr=5, data=0xDEAD_BEEF, held 1 cycle, others idle.
  - req1_ready=1 in that cycle.
  - Next cycle: we3=1, wa3=5, wd3=0xDEADBEEF.
  - Register 5 reads 0xDEADBEEF after the following edge.
- Contention after reset: both valid for 4 cycles.
  - req0 addr=1/data=0x11, req1 addr=2/data=0x22.
  - Grants alternate 0,1,0,1; last_grant toggles each cycle.
  - we3 stays 1 for 4 cycles with wa3 sequence 1,2,1,2.
- XZR discard: req0 valid, addr=31, data=0xFFFF held 3 cycles.
  - ready=1 each cycle; we3 stays 0.
  - xzr_drops goes 0→3; register 31 still reads 0.
- Saturation: CW=8, 300 consecutive X31 writes -> xzr_drops stops at 255.
- Hold: both valid with hold=1 for 3 cycles, then hold=0.
  - No ready and we3=0 during the hold cycles.
  - After release, req0 is granted first (last_grant=1 from reset).
- Async reset mid-write: accept req0 addr=7/data=0x77, then pull reset_n low before the next edge.
  - we3, wa3, wd3 and xzr_drops go to 0 immediately; last_grant goes to 1.
  - Register 7 is not written.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - writeback request and register-file write port bundle
// Requesters drive the master side; the arbiter sits on the slave side.

interface regfile_wr_arbiter_if #(
  parameter int DW = 64,
  parameter int AW = 5
);

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  we3, wa3, wd3
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output we3, wa3, wd3
  );

endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the single register-file write port
// Grants one of two writeback requesters per cycle, registers the winner, drops writes to XZR.

module regfile_wr_arbiter #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hold,
  regfile_wr_arbiter_if.slave bus,
  output logic                last_grant,
  output logic [CW-1:0]       xzr_drops
);

  localparam logic [AW-1:0] XZR_ADDR = AW'(31);
  localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};

  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_is_xzr;

  logic          we3_q;
  logic [AW-1:0] wa3_q;
  logic [DW-1:0] wd3_q;
  logic          last_grant_q;
  logic [CW-1:0] xzr_drops_q;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!hold) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (last_grant_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    accept     = grant0 | grant1;
    sel_addr   = grant1 ? bus.req1_addr : bus.req0_addr;
    sel_data   = grant1 ? bus.req1_data : bus.req0_data;
    sel_is_xzr = (sel_addr == XZR_ADDR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      last_grant_q <= 1'b1;
      xzr_drops_q  <= '0;
    end else if (accept) begin
      last_grant_q <= grant1;
      wa3_q        <= sel_addr;
      wd3_q        <= sel_data;
      we3_q        <= !sel_is_xzr;
      // XZR writes are consumed here and only counted.
      if (sel_is_xzr && (xzr_drops_q != DROP_MAX)) begin
        xzr_drops_q <= xzr_drops_q + CW'(1);
      end
    end else begin
      we3_q <= 1'b0;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.we3        = we3_q;
  assign bus.wa3        = wa3_q;
  assign bus.wd3        = wd3_q;
  assign last_grant     = last_grant_q;
  assign xzr_drops      = xzr_drops_q;

endmodule
